pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter AW, default 8: width of the PC, branch offset and jump address.
REQ-002 SHALL have parameter RAS_DEPTH, default 4: number of return-address-stack entries, power of two, at least 2.
REQ-003 SHALL have parameter RST_VEC, default 0: PC value loaded on reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port stop, input, 1 bit: hold; PC and stack frozen.
REQ-007 SHALL have port br_en, input, 1 bit: conditional-branch instruction present.
REQ-008 SHALL have port br_take, input, 1 bit: branch condition true.
REQ-009 SHALL have port br_off, input, AW bits: signed two's-complement branch offset.
REQ-010 SHALL have port jmp, input, 1 bit: absolute jump.
REQ-011 SHALL have port call, input, 1 bit: subroutine call to jmp_addr.
REQ-012 SHALL have port ret, input, 1 bit: return from subroutine.
REQ-013 SHALL have port jmp_addr, input, AW bits: target for jmp and call.
REQ-014 SHALL have port pc, output, AW bits: current program counter, registered.
REQ-015 SHALL have port ras_cnt, output, clog2(RAS_DEPTH)+1 bits: valid stack entries.
REQ-016 SHALL have port ras_ovf, output, 1 bit: sticky overflow flag.
REQ-017 SHALL have port ras_unf, output, 1 bit: sticky underflow flag.

Function
REQ-018 SHALL define nxt = pc+1, computed modulo 2^AW.
REQ-019 SHALL use per-cycle priority: rst, then stop, then ret, then call, then jmp, then branch, then increment.
REQ-020 SHALL, when the branch path is selected (br_en=1 and br_take=1), load pc <= nxt + sign-extended br_off, wrapping modulo 2^AW.
REQ-021 SHALL, when br_en=1 and br_take=0, or br_en=0, load pc <= nxt.
REQ-022 SHALL, on jmp, load pc <= jmp_addr; the stack is unchanged.
REQ-023 SHALL, on call, load pc <= jmp_addr and push nxt.
REQ-024 SHALL, on a call while full (ras_cnt==RAS_DEPTH), overwrite the oldest entry (circular buffer), keep ras_cnt at RAS_DEPTH, and set ras_ovf.
REQ-025 SHALL, on ret while ras_cnt>0, load pc <= the top entry and pop it.
REQ-026 SHALL, on ret while empty, load pc <= nxt, leave the stack unchanged, and set ras_unf.
REQ-027 SHALL, when call and ret are asserted together, perform ret only; the call is ignored and no push occurs.
REQ-028 SHALL give every control change one cycle of latency: inputs sampled at edge N appear on pc after edge N.
REQ-029 SHALL, while stop=1, hold pc, the stack, ras_cnt and both flags unchanged, regardless of other inputs.
REQ-030 SHALL clear ras_ovf and ras_unf only on reset.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set pc=RST_VEC, ras_cnt=0, ras_ovf=0 and ras_unf=0, overriding stop and all controls.
REQ-032 SHALL, on reset during a call/ret sequence, discard stack contents; entry data need not be cleared.

Configuration
REQ-033 SHALL, with macro PC_SEQ_RAS_EN defined, implement the return stack per REQ-023..027.
REQ-034 SHALL, without PC_SEQ_RAS_EN: treat call as jmp; treat ret as no-op (increment path); instantiate no stack storage; tie ras_cnt, ras_ovf and ras_unf to 0.

Structure
REQ-035 SHALL place in shared package pc_seq_pkg: a next-PC source enum (NPC_INC, NPC_BR, NPC_JMP, NPC_CALL, NPC_RET, NPC_HOLD) and a default AW constant.
REQ-036 SHALL place the return stack in sub-module pc_ras (push, pop, top, cnt, ovf, unf), instantiated only under PC_SEQ_RAS_EN.

Verification
REQ-037 SHALL cover reset then 3 free-running cycles -> pc goes 0, 1, 2, 3.
REQ-038 SHALL cover pc=0x10, br_en=1, br_take=1, br_off=0xFE -> pc=0x0F; same with br_take=0 -> pc=0x11.
REQ-039 SHALL cover pc=0xFF with increment -> pc=0x00; pc=0xF0 with br_off=0x20 -> pc=0x11.
REQ-040 SHALL cover call 0x40 from pc=0x05, then ret -> pc=0x40, then 0x06, with ras_cnt going 1 then 0.
REQ-041 SHALL cover five nested calls at RAS_DEPTH=4 -> ras_ovf=1 and ras_cnt=4; five rets -> first four return to the newest four addresses, fifth sets ras_unf and pc=nxt.
REQ-042 SHALL cover stop=1 with jmp=1 and call=1 asserted -> pc and ras_cnt unchanged; rst=1 with stop=1 -> pc=RST_VEC and flags cleared.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
// Optional return-address stack is enabled with macro PC_SEQ_RAS_EN.
package pc_seq_pkg;

  localparam int PC_SEQ_AW = 8;

  typedef enum logic [2:0] {
    NPC_INC,
    NPC_BR,
    NPC_JMP,
    NPC_CALL,
    NPC_RET,
    NPC_HOLD
  } npc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry and latches the overflow flag. A pop while empty latches underflow.
// The push and pop strobes come from pc_seq, which never asserts both at once.
// If both did arrive together, pop would win.
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int AW    = PC_SEQ_AW,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            push_data,
  output logic [AW-1:0]            top,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  // The newest entry sits one slot behind the write pointer.
  assign rp  = wp - PW'(1);
  assign top = mem[rp];

  // Entry storage needs no reset because the count decides which slots are valid.
  always_ff @(posedge clk) begin
    if (push && !pop) begin
      mem[wp] <= push_data;
    end
  end

  // Pointer, occupancy and sticky flags. Only reset clears the flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (pop) begin
      if (cnt != '0) begin
        wp  <= rp;
        cnt <= cnt - 1'b1;
      end else begin
        unf <= 1'b1;
      end
    end else if (push) begin
      wp <= wp + PW'(1);
      if (cnt == FULL) begin
        ovf <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer. It handles increment, relative branch,
// absolute jump, and optionally call/return.
// Define PC_SEQ_RAS_EN to build the return-address stack. Without it,
// call behaves as a jump and ret takes the increment path.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int              AW        = PC_SEQ_AW,
  parameter int              RAS_DEPTH = 4,
  parameter logic [AW-1:0]   RST_VEC   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stop,
  input  logic                         br_en,
  input  logic                         br_take,
  input  logic [AW-1:0]                br_off,
  input  logic                         jmp,
  input  logic                         call,
  input  logic                         ret,
  input  logic [AW-1:0]                jmp_addr,
  output logic [AW-1:0]                pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  npc_src_e      src;
  logic [AW-1:0] nxt;
  logic [AW-1:0] pc_d;
  logic          ras_valid;

  // The offset has the same width as pc, so modulo addition handles sign extension.
  assign nxt = pc + AW'(1);

`ifdef PC_SEQ_RAS_EN
  logic [AW-1:0] ras_top;
  logic          ras_push;
  logic          ras_pop;

  assign ras_valid = (ras_cnt != '0);
  assign ras_push  = (src == NPC_CALL);
  assign ras_pop   = ret && !stop;

  pc_ras #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (nxt),
    .top       (ras_top),
    .cnt       (ras_cnt),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );
`else
  assign ras_valid = 1'b0;
  assign ras_cnt   = '0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;
`endif

  // Choose the next-PC source. Priority is stop, ret, call, jmp, branch, then increment.
  always_comb begin
    src = NPC_INC;
    if (stop) begin
      src = NPC_HOLD;
    end else if (ret) begin
      src = ras_valid ? NPC_RET : NPC_INC;
    end else if (call) begin
      src = NPC_CALL;
    end else if (jmp) begin
      src = NPC_JMP;
    end else if (br_en && br_take) begin
      src = NPC_BR;
    end
  end

  // Compute the next PC value for the selected source.
  always_comb begin
    pc_d = nxt;
    case (src)
      NPC_HOLD: pc_d = pc;
      NPC_BR:   pc_d = nxt + br_off;
      NPC_JMP:  pc_d = jmp_addr;
      NPC_CALL: pc_d = jmp_addr;
`ifdef PC_SEQ_RAS_EN
      NPC_RET:  pc_d = ras_top;
`endif
      default:  pc_d = nxt;
    endcase
  end

  // PC register. Reset overrides everything, including stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RST_VEC;
    end else begin
      pc <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Testbench for pc_seq. It compares the DUT against a queue-based reference
// model that follows the same PC_SEQ_RAS_EN setting as the design.
module tb_pc_seq;

  localparam int AW        = 8;
  localparam int RAS_DEPTH = 4;
  localparam int RST_VEC   = 0;
  localparam int MASK      = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst, stop, br_en, br_take, jmp, call, ret;
  logic [AW-1:0] br_off, jmp_addr;
  logic [AW-1:0] pc;
  logic [2:0]    ras_cnt;
  logic          ras_ovf, ras_unf;

  int m_pc;
  int m_q[$];
  bit m_ovf, m_unf;

  int n_checks = 0;
  int n_fail   = 0;

  pc_seq #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH),
    .RST_VEC   (AW'(RST_VEC))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stop     (stop),
    .br_en    (br_en),
    .br_take  (br_take),
    .br_off   (br_off),
    .jmp      (jmp),
    .call     (call),
    .ret      (ret),
    .jmp_addr (jmp_addr),
    .pc       (pc),
    .ras_cnt  (ras_cnt),
    .ras_ovf  (ras_ovf),
    .ras_unf  (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rst = 0; stop = 0; br_en = 0; br_take = 0; br_off = '0;
    jmp = 0; call = 0; ret = 0; jmp_addr = '0;
  endtask

  // Apply the architectural rules to the model, then clock the DUT once.
  task automatic tick();
    int n;
    n = (m_pc + 1) & MASK;
    if (rst) begin
      m_pc = RST_VEC; m_q.delete(); m_ovf = 0; m_unf = 0;
    end else if (stop) begin
      m_pc = m_pc;
    end else if (ret) begin
`ifdef PC_SEQ_RAS_EN
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin m_pc = n; m_unf = 1; end
`else
      m_pc = n;
`endif
    end else if (call) begin
`ifdef PC_SEQ_RAS_EN
      if (m_q.size() == RAS_DEPTH) begin m_q.delete(0); m_ovf = 1; end
      m_q.push_back(n);
`endif
      m_pc = int'(jmp_addr);
    end else if (jmp) begin
      m_pc = int'(jmp_addr);
    end else if (br_en && br_take) begin
      m_pc = (n + int'(br_off)) & MASK;
    end else begin
      m_pc = n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input logic [AW-1:0] a);
    clear_inputs(); jmp = 1; jmp_addr = a; tick(); clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs(); rst = 1; tick(); clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs(); rst = 1; stop = 1; jmp = 1; jmp_addr = 8'h77; tick();
    n_checks++;
    if (pc !== AW'(RST_VEC)) begin n_fail++; $display("[TB] FAIL reset_pc got %h want %h", pc, AW'(RST_VEC)); end
    n_checks++;
    if (ras_cnt !== 3'd0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_ras got cnt=%0d ovf=%b unf=%b want 0/0/0", ras_cnt, ras_ovf, ras_unf);
    end
    clear_inputs();
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (pc !== AW'(i)) begin n_fail++; $display("[TB] FAIL free_run_%0d got %h want %h", i, pc, AW'(i)); end
    end
  endtask

  task automatic test_branch();
    goto(8'h10);
    br_en = 1; br_take = 1; br_off = 8'hFE; tick();
    n_checks++;
    if (pc !== 8'h0F) begin n_fail++; $display("[TB] FAIL branch_back got %h want 0f", pc); end
    goto(8'h10);
    br_en = 1; br_take = 0; br_off = 8'hFE; tick();
    n_checks++;
    if (pc !== 8'h11) begin n_fail++; $display("[TB] FAIL branch_not_taken got %h want 11", pc); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    goto(8'hFF);
    tick();
    n_checks++;
    if (pc !== 8'h00) begin n_fail++; $display("[TB] FAIL inc_wrap got %h want 00", pc); end
    goto(8'hF0);
    br_en = 1; br_take = 1; br_off = 8'h20; tick();
    n_checks++;
    if (pc !== 8'h11) begin n_fail++; $display("[TB] FAIL branch_wrap got %h want 11", pc); end
    clear_inputs();
  endtask

  task automatic test_call_ret();
    do_reset();
    goto(8'h05);
    call = 1; jmp_addr = 8'h40; tick(); clear_inputs();
    n_checks++;
    if (pc !== 8'h40) begin n_fail++; $display("[TB] FAIL call_pc got %h want 40", pc); end
    n_checks++;
    if (ras_cnt !== 3'(m_q.size())) begin n_fail++; $display("[TB] FAIL call_cnt got %0d want %0d", ras_cnt, m_q.size()); end
    ret = 1; tick(); clear_inputs();
    n_checks++;
    if (pc !== AW'(m_pc)) begin n_fail++; $display("[TB] FAIL ret_pc got %h want %h", pc, AW'(m_pc)); end
`ifdef PC_SEQ_RAS_EN
    n_checks++;
    if (pc !== 8'h06) begin n_fail++; $display("[TB] FAIL ret_pc_const got %h want 06", pc); end
`endif
    n_checks++;
    if (ras_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL ret_cnt got %0d want 0", ras_cnt); end
    // call and ret together: ret wins, nothing pushed
    ret = 1; call = 1; jmp_addr = 8'h90; tick(); clear_inputs();
    n_checks++;
    if (pc !== AW'(m_pc) || ras_cnt !== 3'(m_q.size()) || ras_unf !== m_unf) begin
      n_fail++; $display("[TB] FAIL call_ret_both got pc=%h cnt=%0d unf=%b want pc=%h cnt=%0d unf=%b",
                         pc, ras_cnt, ras_unf, AW'(m_pc), m_q.size(), m_unf);
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] exp_ret [5];
    exp_ret = '{8'h51, 8'h41, 8'h31, 8'h21, 8'h22};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      call = 1; jmp_addr = AW'(8'h20 + 8'h10 * i); tick(); clear_inputs();
    end
    n_checks++;
    if (ras_cnt !== 3'(m_q.size()) || ras_ovf !== m_ovf) begin
      n_fail++; $display("[TB] FAIL ovf_state got cnt=%0d ovf=%b want cnt=%0d ovf=%b", ras_cnt, ras_ovf, m_q.size(), m_ovf);
    end
`ifdef PC_SEQ_RAS_EN
    n_checks++;
    if (ras_cnt !== 3'd4 || ras_ovf !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ovf_const got cnt=%0d ovf=%b want cnt=4 ovf=1", ras_cnt, ras_ovf);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      ret = 1; tick(); clear_inputs();
      n_checks++;
      if (pc !== AW'(m_pc) || ras_cnt !== 3'(m_q.size())) begin
        n_fail++; $display("[TB] FAIL ret_seq_%0d got pc=%h cnt=%0d want pc=%h cnt=%0d", i, pc, ras_cnt, AW'(m_pc), m_q.size());
      end
`ifdef PC_SEQ_RAS_EN
      n_checks++;
      if (pc !== exp_ret[i]) begin n_fail++; $display("[TB] FAIL ret_const_%0d got %h want %h", i, pc, exp_ret[i]); end
`endif
    end
    n_checks++;
    if (ras_unf !== m_unf) begin n_fail++; $display("[TB] FAIL unf_flag got %b want %b", ras_unf, m_unf); end
`ifdef PC_SEQ_RAS_EN
    n_checks++;
    if (ras_unf !== 1'b1 || ras_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL sticky_flags got ovf=%b unf=%b want 1/1", ras_ovf, ras_unf); end
`endif
  endtask

  task automatic test_stop();
    logic [AW-1:0] held_pc;
    logic [2:0]    held_cnt;
    call = 1; jmp_addr = 8'h33; tick(); clear_inputs();
    held_pc = pc; held_cnt = ras_cnt;
    stop = 1; jmp = 1; call = 1; jmp_addr = 8'hAA;
    tick(); tick();
    n_checks++;
    if (pc !== AW'(m_pc) || pc !== held_pc) begin n_fail++; $display("[TB] FAIL stop_pc got %h want %h", pc, held_pc); end
    n_checks++;
    if (ras_cnt !== held_cnt || ras_cnt !== 3'(m_q.size())) begin n_fail++; $display("[TB] FAIL stop_cnt got %0d want %0d", ras_cnt, held_cnt); end
    rst = 1; tick(); clear_inputs();
    n_checks++;
    if (pc !== AW'(RST_VEC) || ras_cnt !== 3'd0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_over_stop got pc=%h cnt=%0d ovf=%b unf=%b want %h/0/0/0", pc, ras_cnt, ras_ovf, ras_unf, AW'(RST_VEC));
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      stop     = ($urandom_range(0, 7) == 0);
      ret      = ($urandom_range(0, 5) == 0);
      call     = ($urandom_range(0, 4) == 0);
      jmp      = ($urandom_range(0, 7) == 0);
      br_en    = $urandom_range(0, 1) == 1;
      br_take  = $urandom_range(0, 1) == 1;
      br_off   = AW'($urandom);
      jmp_addr = AW'($urandom);
      tick();
      n_checks++;
      if (pc !== AW'(m_pc) || ras_cnt !== 3'(m_q.size()) || ras_ovf !== m_ovf || ras_unf !== m_unf) begin
        n_fail++;
        $display("[TB] FAIL random_%0d got pc=%h cnt=%0d ovf=%b unf=%b want pc=%h cnt=%0d ovf=%b unf=%b",
                 i, pc, ras_cnt, ras_ovf, ras_unf, AW'(m_pc), m_q.size(), m_ovf, m_unf);
      end
    end
    clear_inputs();
  endtask

  initial begin
    m_pc = 0; m_ovf = 0; m_unf = 0;
    clear_inputs();
    @(posedge clk); #1;
    test_reset();
    test_branch();
    test_wrap();
    test_call_ret();
    test_overflow();
    test_stop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
